fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage feeding decoder_glue. Holds the fetch PC and drives a
//   req/ack instruction-memory port; memory may answer in the request cycle or after
//   wait states. Delivers {instr, pc, pc+4} to decode over a valid/ready handshake,
//   with a 1-entry skid buffer. Taken branches and jumps redirect the PC, and
//   in-flight or buffered wrong-path instructions are discarded.
// PARAMETERS
//   RESET_PC   32'h0000_0000  fetch address after reset (word aligned)
//   NOP_INSTR  32'h0000_0013  value of out_instr while nothing valid (addi x0,x0,0)
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   synchronous reset, active high
//   imem_req        out  1   fetch request; held with imem_addr stable until imem_ack
//   imem_addr       out  32  word-aligned fetch address ([1:0] always 00)
//   imem_ack        in   1   rdata valid this cycle; ignored when imem_req=0
//   imem_rdata      in   32  fetched instruction word
//   redirect_valid  in   1   taken branch/JAL/JALR from execute, one-cycle pulse
//   redirect_pc     in   32  redirect target; bits [1:0] ignored (treated as 00)
//   out_valid       out  1   out_* hold a valid instruction for decode
//   out_ready       in   1   decode accepts out_* this cycle
//   out_instr       out  32  instruction to decoder_glue.instr
//   out_pc          out  32  address of out_instr
//   out_pc_plus4    out  32  out_pc + 4, mod 2^32 (JAL/JALR link value)
// BEHAVIOUR
// - Reset (rst=1 at a clock edge)
//   - Sets fetch_pc=RESET_PC, state RUN, out_valid=0, skid empty.
//   - Sets out_instr=NOP_INSTR, out_pc=RESET_PC, out_pc_plus4=RESET_PC+4.
//   - imem_req=0 while rst=1. rst wins over all other inputs.
//   - Reset mid-transaction abandons the request; imem shares rst.
// - States: RUN, DRAIN.
//   - RUN:   imem_req = !skid_valid, imem_addr = fetch_pc.
//   - DRAIN: imem_req = 1 at the old address until ack; ack data is discarded.
// - Request rules
//   - Once imem_req rises, req and imem_addr stay constant until the ack cycle.
//   - imem_req may drop only in the cycle after an ack, and only when the skid is full.
// - Accepted ack (RUN, no redirect)
//   - fetch_pc <= fetch_pc + 4, wrapping mod 2^32.
//   - Data goes to the output register if (!out_valid || out_ready); otherwise to the skid.
//   - Output register update: out_pc = the acked address, out_pc_plus4 = +4, out_valid <= 1.
// - Output handshake
//   - Transfer happens when out_valid && out_ready.
//   - On transfer, skid contents (if any) move to the output register in the same edge, else out_valid <= 0.
//   - Order is strictly program order: no loss, no duplication.
//   - out_* are stable while out_valid && !out_ready.
//   - When out_valid=0, out_instr=NOP_INSTR.
// - Latency: zero-wait memory gives acked data on out_* the next cycle; throughput is 1 instr/cycle.
// - Redirect (priority over ack and handshake)
//   - Always: out_valid <= 0 and skid cleared next cycle. A transfer in the redirect cycle still counts.
//   - If no request is outstanding, or the ack arrives in the same cycle: ack data discarded, fetch_pc <= redirect_pc, stay RUN.
//   - If a request is waiting (req=1, ack=0): pending_pc <= redirect_pc, go to DRAIN.
//     - In DRAIN, a new redirect overwrites pending_pc (last wins).
//     - On the ack: discard data, fetch_pc <= pending_pc, go to RUN; the next request uses the new PC.
// - No misalignment trap is raised; target bits [1:0] are dropped silently.
// TESTING
//   1 Reset release, RESET_PC=0, ack same cycle, out_ready=1
//     -> imem_addr 0,4,8 on consecutive cycles; out_pc 0,4,8 one cycle later;
//        out_pc_plus4=out_pc+4.
//   2 Zero-wait mem, out_ready=0 for 5 cycles, then 1
//     -> two words captured (output+skid) and imem_req drops;
//        after release, out_pc 0,4,8,C in order, no gaps or repeats.
//   3 ack delayed 3 cycles, rdata=32'h00500293
//     -> imem_addr stable for 4 cycles; out_instr=00500293 with out_valid 1 cycle after ack.
//   4 redirect_valid, redirect_pc=0x100, while req at 0x8 is waiting; ack 2 cycles later with DEADBEEF
//     -> DEADBEEF never on out_*; next imem_addr=0x100; out_valid low until 0x100 data.
//   5 Redirect to 0x203 in the same cycle as the ack for 0xC; also rst asserted mid-wait
//     -> next addr 0x200, 0xC data dropped;
//        after rst: out_valid=0, out_instr=NOP_INSTR, next imem_addr=RESET_PC.
//   6 Redirect to 0xFFFF_FFFC
//     -> out_pc=FFFFFFFC, out_pc_plus4=0, next imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with req/ack imem port, 1-entry skid and redirect drain
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] pending_pc;
  logic [31:0] instr_q;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        ack_ok;
  logic        xfer;
  logic [31:0] target;

  assign target       = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr    = fetch_pc;
  assign ack_ok       = imem_req && imem_ack;
  assign xfer         = out_valid && out_ready;
  assign out_instr    = out_valid ? instr_q : NOP_INSTR;
  assign out_pc_plus4 = out_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    if (!rst) begin
      imem_req = (state == DRAIN) ? 1'b1 : !skid_valid;
    end
    // A request still waiting at redirect time must be finished before the new PC is used
    if (redirect_valid) begin
      state_nx = (imem_req && !imem_ack) ? DRAIN : RUN;
    end else if (state == DRAIN && imem_ack) begin
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= RESET_PC;
      out_valid  <= 1'b0;
      out_pc     <= RESET_PC;
      instr_q    <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      if (imem_req && !imem_ack) pending_pc <= target;
      else                       fetch_pc   <= target;
    end else if (state == DRAIN) begin
      if (imem_ack) fetch_pc <= pending_pc;
    end else begin
      if (xfer) begin
        if (skid_valid) begin
          instr_q    <= skid_instr;
          out_pc     <= skid_pc;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= 1'b0;
        end
      end
      // In RUN an ack implies the skid is empty, so it never collides with the skid move above
      if (ack_ok) begin
        fetch_pc <= fetch_pc + 32'd4;
        if (!out_valid || out_ready) begin
          instr_q   <= imem_rdata;
          out_pc    <= fetch_pc;
          out_valid <= 1'b1;
        end else begin
          skid_instr <= imem_rdata;
          skid_pc    <= fetch_pc;
          skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  logic        ovr_en;
  logic [31:0] ovr_data;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // Memory returns 0x1000_0000 | addr unless a specific word is forced
  assign imem_rdata = ovr_en ? ovr_data : (32'h1000_0000 | imem_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_pc4"}, out_pc_plus4, pc + 32'd4);
    chk({tag, "_instr"}, out_instr, 32'h1000_0000 | pc);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0; ovr_en = 1'b0; ovr_data = 32'd0;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc4", out_pc_plus4, 32'd4);

    // Streaming with zero-wait memory
    rst = 1'b0; #1;
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_req0", {31'd0, imem_req}, 32'd1);
    tick(); chk("t1_addr4", imem_addr, 32'h4); chk_out("t1_o0", 32'h0);
    tick(); chk("t1_addr8", imem_addr, 32'h8); chk_out("t1_o4", 32'h4);
    tick(); chk("t1_addrc", imem_addr, 32'hC); chk_out("t1_o8", 32'h8);

    // Backpressure: 0x8 held in output, 0xC captured in skid, request drops
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_req_low", {31'd0, imem_req}, 32'd0);
      chk_out("t2_hold", 32'h8);
    end
    out_ready = 1'b1;
    tick(); chk_out("t2_oc", 32'hC); chk("t2_addr10", imem_addr, 32'h10);
    chk("t2_req_up", {31'd0, imem_req}, 32'd1);
    tick(); chk_out("t2_o10", 32'h10); chk("t2_addr14", imem_addr, 32'h14);

    // Wait states: ack for 0x14 arrives after 3 stalled cycles
    imem_ack = 1'b0;
    tick(); chk("t3_valid0", {31'd0, out_valid}, 32'd0); chk("t3_nop", out_instr, NOP);
    for (int i = 0; i < 2; i++) begin
      tick(); chk("t3_addr_hold", imem_addr, 32'h14);
      chk("t3_req_hold", {31'd0, imem_req}, 32'd1);
    end
    imem_ack = 1'b1; ovr_en = 1'b1; ovr_data = 32'h0050_0293;
    tick(); imem_ack = 1'b0; ovr_en = 1'b0;
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_instr", out_instr, 32'h0050_0293);
    chk("t3_pc", out_pc, 32'h14);
    tick(); chk("t3_addr18", imem_addr, 32'h18); chk("t3_drained", {31'd0, out_valid}, 32'd0);

    // Redirect while 0x18 waits, then a second redirect during drain (last wins)
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick(); redirect_valid = 1'b0;
    chk("t4_drain_addr", imem_addr, 32'h18); chk("t4_valid0", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(); redirect_valid = 1'b0;
    chk("t4_drain_addr2", imem_addr, 32'h18);
    chk("t4_drain_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    tick(); ovr_en = 1'b0;
    chk("t4_no_beef_v", {31'd0, out_valid}, 32'd0);
    chk("t4_no_beef_i", out_instr, NOP);
    chk("t4_addr100", imem_addr, 32'h100);
    tick(); chk_out("t4_o100", 32'h100); chk("t4_addr104", imem_addr, 32'h104);

    // Redirect to misaligned 0x203 in the same cycle as the ack of 0x104
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick(); redirect_valid = 1'b0;
    chk("t5_addr200", imem_addr, 32'h200); chk("t5_drop", {31'd0, out_valid}, 32'd0);
    tick(); chk_out("t5_o200", 32'h200);
    imem_ack = 1'b0;
    tick(); chk("t5_wait_addr", imem_addr, 32'h204);
    rst = 1'b1; #1;
    chk("t5_rst_req", {31'd0, imem_req}, 32'd0);
    tick(); rst = 1'b0; imem_ack = 1'b1; #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_instr", out_instr, NOP);
    chk("t5_rst_addr", imem_addr, 32'h0);

    // Redirect to the top word: PC and link value wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect_valid = 1'b0;
    chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_pc", out_pc, 32'hFFFF_FFFC);
    chk("t6_pc4", out_pc_plus4, 32'h0);
    chk("t6_instr", out_instr, 32'hFFFF_FFFC);
    chk("t6_wrap", imem_addr, 32'h0);
    tick(); chk_out("t6_o0", 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
